sound_scheduler: RTL

//  Shares the single PmodAMP2 audio output (pmod_1/2/4) between three game-event requesters: countdown tick, goal, end-of-game.

---
 rtl/sound_scheduler.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/sound_scheduler.sv
// sound_scheduler
//   Shares the single PmodAMP2 output between three game-event requesters
//   (countdown tick, goal, end-of-game). It arbitrates by fixed priority
//   (end > goal > tick), steps through each event's note pattern and
//   generates the square-wave tone that drives the amplifier.
//
// Ports
//   clk        system clock (100 MHz nominal)
//   rst        asynchronous, active-low reset
//   req_tick   one-cycle pulse: countdown tick
//   req_goal   one-cycle pulse: goal scored
//   req_end    one-cycle pulse: game over
//   mute       (only with SOUND_MUTE_EN) silences pmod_1/pmod_4; timing unaffected
//   pmod_1     AIN, square-wave audio
//   pmod_2     GAIN, tied to 1 (6 dB)
//   pmod_4     SHUTDOWN_N, amplifier enabled during PLAY and GAP
//   busy       a pattern is playing
//   cur_src    0 none, 1 tick, 2 goal, 3 end (valid only while busy)
//
// Configuration macro
//   SOUND_MUTE_EN  adds the mute input port.
module sound_scheduler #(
    parameter int NOTE_CYC = 10_000_000,
    parameter int GAP_CYC  = 2_000_000,
    parameter int HP_TICK  = 113_636,
    parameter int HP_G0    = 95_557,
    parameter int HP_G1    = 75_843,
    parameter int HP_G2    = 63_776,
    parameter int HP_END   = 227_273
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_tick,
    input  logic       req_goal,
    input  logic       req_end,
`ifdef SOUND_MUTE_EN
    input  logic       mute,
`endif
    output logic       pmod_1,
    output logic       pmod_2,
    output logic       pmod_4,
    output logic       busy,
    output logic [1:0] cur_src
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Counters only ever reach (terminal - 1), so $clog2 of the largest
    // terminal value is enough bits.
    localparam int SEQ_MAX = max2(NOTE_CYC, GAP_CYC);
    localparam int HP_MAX  = max2(max2(HP_TICK, HP_END), max2(HP_G0, max2(HP_G1, HP_G2)));
    localparam int SEQ_W   = $clog2(SEQ_MAX);
    localparam int HP_W    = $clog2(HP_MAX);

    localparam logic [1:0] SRC_NONE = 2'd0;
    localparam logic [1:0] SRC_TICK = 2'd1;
    localparam logic [1:0] SRC_GOAL = 2'd2;
    localparam logic [1:0] SRC_END  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_GAP
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       pend_q, pend_d;      // bit i holds a request for source i+1
    logic [1:0]       src_q, src_d;
    logic [1:0]       slot_q, slot_d;
    logic [SEQ_W-1:0] seq_cnt_q, seq_cnt_d; // note-slot length in PLAY, gap length in GAP
    logic [HP_W-1:0]  hp_cnt_q, hp_cnt_d;
    logic             tone_q, tone_d;

    logic [2:0]       req_vec;
    logic [2:0]       eff;
    logic [1:0]       top;
    logic             start;
    logic             hp_term;
    logic             note_term;
    logic             gap_term;
    logic             last_slot;
    logic             play;
    logic             mute_i;

    // Highest-priority source among the asserted bits.
    function automatic logic [1:0] top_src(input logic [2:0] v);
        if (v[2])      return SRC_END;
        else if (v[1]) return SRC_GOAL;
        else if (v[0]) return SRC_TICK;
        else           return SRC_NONE;
    endfunction

    function automatic logic [2:0] src_mask(input logic [1:0] s);
        case (s)
            SRC_TICK: return 3'b001;
            SRC_GOAL: return 3'b010;
            SRC_END:  return 3'b100;
            default:  return 3'b000;
        endcase
    endfunction

    // Terminal half-period count for the note currently in play.
    function automatic logic [HP_W-1:0] hp_last(input logic [1:0] s, input logic [1:0] slot);
        case (s)
            SRC_TICK: return HP_W'(HP_TICK - 1);
            SRC_GOAL: begin
                case (slot)
                    2'd0:    return HP_W'(HP_G0 - 1);
                    2'd1:    return HP_W'(HP_G1 - 1);
                    default: return HP_W'(HP_G2 - 1);
                endcase
            end
            SRC_END:  return HP_W'(HP_END - 1);
            default:  return '0;
        endcase
    endfunction

    function automatic logic [1:0] last_slot_of(input logic [1:0] s);
        case (s)
            SRC_GOAL: return 2'd2;
            SRC_END:  return 2'd3;
            default:  return 2'd0;
        endcase
    endfunction

    assign req_vec   = {req_end, req_goal, req_tick};
    // A request in this cycle is visible to arbitration immediately, so a
    // pulse in cycle N from IDLE is already playing in cycle N+1.
    assign eff       = pend_q | req_vec;
    assign top       = top_src(eff);
    assign hp_term   = (hp_cnt_q == hp_last(src_q, slot_q));
    assign note_term = (seq_cnt_q == SEQ_W'(NOTE_CYC - 1));
    assign gap_term  = (seq_cnt_q == SEQ_W'(GAP_CYC - 1));
    assign last_slot = (slot_q == last_slot_of(src_q));

    always_comb begin
        state_d   = state_q;
        pend_d    = eff;   // new requests merge into pending bits
        src_d     = src_q;
        slot_d    = slot_q;
        seq_cnt_d = seq_cnt_q;
        hp_cnt_d  = hp_cnt_q;
        tone_d    = tone_q;
        start     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (top != SRC_NONE) start = 1'b1;
            end
            S_PLAY: begin
                // Only a strictly higher source preempts; the aborted
                // pattern is simply dropped.
                if (top > src_q) begin
                    start = 1'b1;
                end else begin
                    if (hp_term) begin
                        hp_cnt_d = '0;
                        tone_d   = ~tone_q;
                    end else begin
                        hp_cnt_d = hp_cnt_q + 1'b1;
                    end
                    if (note_term) begin
                        seq_cnt_d = '0;
                        hp_cnt_d  = '0;
                        tone_d    = 1'b0;
                        if (last_slot) state_d = S_GAP;
                        else           slot_d  = slot_q + 2'd1;
                    end else begin
                        seq_cnt_d = seq_cnt_q + 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (gap_term) begin
                    state_d   = S_IDLE;
                    seq_cnt_d = '0;
                end else begin
                    seq_cnt_d = seq_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (start) begin
            state_d   = S_PLAY;
            src_d     = top;
            slot_d    = 2'd0;
            seq_cnt_d = '0;
            hp_cnt_d  = '0;
            tone_d    = 1'b0;
            pend_d    = eff & ~src_mask(top);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            pend_q    <= '0;
            src_q     <= SRC_NONE;
            slot_q    <= '0;
            seq_cnt_q <= '0;
            hp_cnt_q  <= '0;
            tone_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            src_q     <= src_d;
            slot_q    <= slot_d;
            seq_cnt_q <= seq_cnt_d;
            hp_cnt_q  <= hp_cnt_d;
            tone_q    <= tone_d;
        end
    end

`ifdef SOUND_MUTE_EN
    assign mute_i = mute;
`else
    assign mute_i = 1'b0;
`endif

    // Outputs decode registered state only, so reset silences them at once.
    assign play    = (state_q == S_PLAY);
    assign busy    = play;
    assign cur_src = play ? src_q : SRC_NONE;
    assign pmod_1  = tone_q & play & ~mute_i;
    assign pmod_4  = (state_q != S_IDLE) & ~mute_i;
    assign pmod_2  = 1'b1;

endmodule
